imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart of the read-only instruction memory: accepts a framed byte stream and writes it into the writable instruction-memory port, one 8-bit instruction per location from address 0 upward.
- Holds the core in reset while loading; releases it only after a good checksum.
- Sits between the host/debug byte link and the instruction memory write port.

Parameters:
DEPTH, 64, number of instruction-memory locations; maximum accepted program length
ADDR_W, 8, width of mem_addr
DATA_W, 8, width of in_data, mem_wdata and checksum

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: begin a new load
abort  input  1  one-cycle pulse: cancel the current load
in_valid  input  1  upstream byte valid
in_data  input  DATA_W  upstream byte
in_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  instruction-memory write enable
mem_addr  output  ADDR_W  instruction-memory write address
mem_wdata  output  DATA_W  instruction-memory write data
cpu_hold  output  1  keep core in reset
busy  output  1  load in progress
done  output  1  last load completed with good checksum (sticky)
error  output  1  last load failed (sticky)
words_written  output  ADDR_W  instructions written in current/last load

Behaviour:
- Interface: one clock; reset is synchronous and active-high, on clk and rst.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, busy=0, done=0, error=0, words_written=0; state IDLE.
- Frame: LEN byte (N), then N instruction bytes, then CSUM byte. CSUM must equal the mod-256 sum of the N instruction bytes. LEN is not included in the sum.
- Handshake: a byte transfers when in_valid && in_ready on a rising edge. in_ready is 1 exactly in states LEN, DATA and CSUM, and 0 elsewhere. No combinational path from in_valid to in_ready.
- States:
  - IDLE: start -> LEN. Set busy=1, cpu_hold=1; clear done, error, words_written, addr counter and sum.
  - LEN: accept N. If N==0 or N>DEPTH -> ERR; else store N and go to DATA.
  - DATA: on each accepted byte:
    - Add the byte to sum (mod 256).
    - Next cycle: mem_we=1, mem_addr=counter, mem_wdata=byte (one-cycle write latency, registered outputs).
    - Increment counter and words_written.
    - After the Nth byte go to CSUM.
  - CSUM: accept byte. Equal to sum -> DONE; else -> ERR.
  - DONE: done=1, busy=0, cpu_hold=0. Return to IDLE next cycle; done stays sticky until the next start or rst.
  - ERR: error=1, busy=0, cpu_hold=1. Return to IDLE next cycle; error stays sticky until the next start or rst.
- mem_we is a single-cycle pulse per instruction. It is never asserted outside the cycle after a DATA transfer.
- Back-to-back: one byte per cycle sustained. A write issued for byte k coincides with acceptance of byte k+1.
- Gaps: in_valid low stalls with no state change.
- Start while busy is ignored.
- abort in LEN/DATA/CSUM -> ERR next cycle.
  - A pending mem_we from the final accepted byte still completes.
  - abort takes priority over a simultaneous transfer, which is dropped.
- abort in IDLE/DONE/ERR is ignored.
- rst mid-load: outputs return to reset values on the next edge. Memory contents already written are left as-is. cpu_hold=1.
- A failed or aborted load leaves partially written memory; cpu_hold remains 1 until a successful load.
- Address wrap: N<=DEPTH guarantees mem_addr never exceeds DEPTH-1; no wrap occurs.

Test Plan:
- Reset, then idle 5 cycles -> all outputs at reset values; cpu_hold=1; in_ready=0; no mem_we.
- start; stream 03, 0A, 14, 1E, CSUM 3C at one byte/cycle -> mem_we pulses at addr 0,1,2 with data 0A,14,1E, one cycle after each accept; done=1, cpu_hold=0, words_written=3, error=0.
- Same frame with CSUM 3D -> three writes still occur; error=1, done=0, cpu_hold=1.
- LEN=00, then a second run with LEN=41 (65) -> error=1 immediately after LEN; no mem_we at any time.
- LEN=40 (64) with bytes 00..3F and correct CSUM E0, in_valid toggled every other cycle -> 64 writes with addr 0..63 matching data; no extra writes; done=1.
- start; LEN=04; 2 data bytes; then abort coincident with a valid third byte -> third byte dropped; exactly 2 writes; error=1. A second start in mid-frame is ignored, and rst mid-frame returns to reset values the next cycle.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (LEN, N instruction bytes, CSUM)
// and writes each instruction byte into the instruction memory from address 0
// upward. The core is held in reset while a load runs and is released only
// after the checksum matches.
//
// Ports:
//   clk, rst       - system clock; synchronous active-high reset
//   start, abort   - one-cycle pulses: begin a load / cancel the current load
//   in_valid,
//   in_data,
//   in_ready       - upstream byte handshake (transfer on valid && ready)
//   mem_we,
//   mem_addr,
//   mem_wdata      - instruction-memory write port (registered, one pulse per byte)
//   cpu_hold       - keep the core in reset
//   busy           - load in progress
//   done, error    - sticky result of the last load
//   words_written  - instruction bytes written by the current/last load
module imem_loader #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_written
);

  typedef enum logic [2:0] {StIdle, StLen, StData, StCsum, StDone, StErr} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_inc;
  logic [DATA_W-1:0] sum_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              done_q;
  logic              error_q;
  logic              hold_q;

  logic xfer;
  logic len_ok;
  logic last_byte;

  // abort wins over a coincident transfer, so the byte is dropped.
  assign xfer      = in_valid && in_ready && !abort;
  assign len_ok    = (in_data != '0) && (32'(in_data) <= DEPTH);
  assign cnt_inc   = cnt_q + ADDR_W'(1);
  assign last_byte = (cnt_inc == len_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; in_valid alone implies a transfer in the accepting states
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLen;
      end
      StLen: begin
        if (abort) begin
          state_d = StErr;
        end else if (in_valid) begin
          state_d = len_ok ? StData : StErr;
        end
      end
      StData: begin
        if (abort) begin
          state_d = StErr;
        end else if (in_valid && last_byte) begin
          state_d = StCsum;
        end
      end
      StCsum: begin
        if (abort) begin
          state_d = StErr;
        end else if (in_valid) begin
          state_d = (in_data == sum_q) ? StDone : StErr;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state only, so in_ready never depends on in_valid
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      StLen, StData, StCsum: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Datapath, write port and sticky status
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      we_q <= (state_q == StData) && xfer;

      if (state_q == StIdle && start) begin
        cnt_q   <= '0;
        sum_q   <= '0;
        done_q  <= 1'b0;
        error_q <= 1'b0;
        hold_q  <= 1'b1;
      end

      if (state_q == StLen && xfer) begin
        len_q <= ADDR_W'(in_data);
      end

      if (state_q == StData && xfer) begin
        addr_q  <= cnt_q;
        wdata_q <= in_data;
        cnt_q   <= cnt_inc;
        sum_q   <= sum_q + in_data;
      end

      // StDone/StErr are only ever entered from the accepting states
      if (state_d == StDone) begin
        done_q <= 1'b1;
        hold_q <= 1'b0;
      end

      if (state_d == StErr) begin
        error_q <= 1'b1;
        hold_q  <= 1'b1;
      end
    end
  end

  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign cpu_hold      = hold_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader. The reference model derives
// expected writes, their cycles and the final status straight from the frame
// contents.
module tb_imem_loader;

  localparam int unsigned DEPTH = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] words_written;

  imem_loader #(
    .DEPTH  (DEPTH),
    .ADDR_W (8),
    .DATA_W (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .cpu_hold      (cpu_hold),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        obs_q[$];
  logic [7:0] payload[$];

  // Write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we) obs_q.push_back('{int'(mem_addr), int'(mem_wdata), cyc});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte until accepted; acc_cyc is the cycle that follows the transfer edge.
  task automatic send(input logic [7:0] b, output int acc_cyc);
    bit ok;
    ok       = 1'b0;
    acc_cyc  = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        tick();
        ok      = 1'b1;
        acc_cyc = cyc;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic gap(input int mode);
    if (mode == 1) tick();
    else if (mode == 2) repeat ($urandom_range(0, 2)) tick();
  endtask

  // gap_mode: 0 back-to-back, 1 every other cycle, 2 random gaps.
  // abort_at: data index at which abort coincides with a valid byte (-1 for none).
  task automatic run_frame(input int n, input logic [7:0] csum, input int gap_mode,
                           input int abort_at, input bit mid_start);
    int         acc;
    int         sent;
    bit         len_ok;
    bit         aborted;
    bit         exp_done;
    logic [7:0] sum;
    sum     = 8'd0;
    sent    = 0;
    aborted = 1'b0;
    exp_q.delete();
    obs_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("hold_after_start", cpu_hold, 1);
    check("done_cleared", done, 0);
    check("error_cleared", error, 0);
    check("words_cleared", words_written, 0);
    check("ready_in_len", in_ready, 1);

    send(8'(n), acc);
    len_ok = (n >= 1) && (n <= int'(DEPTH));
    if (!len_ok) begin
      check("len_err_now", error, 1);
      check("len_err_hold", cpu_hold, 1);
    end else begin
      gap(gap_mode);
      for (int k = 0; k < n; k++) begin
        if (k == abort_at) begin
          in_valid = 1'b1;
          in_data  = payload[k];
          abort    = 1'b1;
          tick();
          abort    = 1'b0;
          in_valid = 1'b0;
          aborted  = 1'b1;
          check("abort_err_now", error, 1);
          break;
        end
        if (mid_start && k == n / 2) start = 1'b1;
        send(payload[k], acc);
        start = 1'b0;
        exp_q.push_back('{k, int'(payload[k]), acc});
        sum += payload[k];
        sent++;
        gap(gap_mode);
      end
      if (!aborted) send(csum, acc);
    end
    in_valid = 1'b0;
    repeat (3) tick();

    exp_done = len_ok && !aborted && (csum == sum);
    check("done", done, 32'(exp_done));
    check("error", error, 32'(!exp_done));
    check("cpu_hold", cpu_hold, 32'(!exp_done));
    check("busy_end", busy, 0);
    check("ready_end", in_ready, 0);
    check("words_written", words_written, 32'(sent));
    check("write_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check("wr_addr", obs_q[i].addr, exp_q[i].addr);
      check("wr_data", obs_q[i].data, exp_q[i].data);
      check("wr_cycle", obs_q[i].cyc, exp_q[i].cyc);
    end
  endtask

  initial begin
    int         acc;
    int         n;
    int         ab;
    logic [7:0] cs;

    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_words", words_written, 0);
    check("rst_no_writes", obs_q.size(), 0);

    // Good three-byte frame, then the same frame with a bad checksum
    payload = '{8'h0A, 8'h14, 8'h1E};
    run_frame(3, 8'h3C, 0, -1, 1'b0);
    run_frame(3, 8'h3D, 0, -1, 1'b0);

    // Illegal lengths
    run_frame(0, 8'h00, 0, -1, 1'b0);
    run_frame(65, 8'h00, 0, -1, 1'b0);

    // Full-depth frame with in_valid toggled every other cycle
    payload.delete();
    for (int i = 0; i < 64; i++) payload.push_back(8'(i));
    run_frame(64, 8'hE0, 1, -1, 1'b0);

    // Abort coincident with the third data byte
    payload = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(4, 8'hAA, 0, 2, 1'b0);

    // Second start mid-frame is ignored
    run_frame(4, 8'hAA, 0, -1, 1'b1);

    // Reset mid-frame
    start = 1'b1;
    tick();
    start = 1'b0;
    send(8'd4, acc);
    send(8'h55, acc);
    rst = 1'b1;
    tick();
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_wdata", mem_wdata, 0);
    check("mid_rst_hold", cpu_hold, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_words", words_written, 0);
    rst = 1'b0;
    tick();

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(65, 255)) * int'($urandom_range(0, 1))
                                     : int'($urandom_range(1, 64));
      payload.delete();
      cs = 8'd0;
      for (int i = 0; i < 64; i++) begin
        payload.push_back(8'($urandom));
        if (i < n) cs += payload[i];
      end
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
      ab = ($urandom_range(0, 4) == 0 && n > 0) ? int'($urandom_range(0, 63)) : -1;
      run_frame(n, cs, 2, ab, 1'($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
